// File: rtl/lift_request_ctrl.sv
// Call latching and SCAN direction control for a single-car lift.
// Move/door commands are Moore outputs registered from the next state; the datapath owns the floor.
module lift_request_ctrl #(
  parameter int NFLOORS      = 6,
  parameter int HOLD_CYCLES  = 4,
  parameter int CLOSE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NFLOORS-1:0] req,
  input  logic [NFLOORS-1:0] Sensor,
  input  logic               Passenger_in,
  output logic               MoveUp,
  output logic               MoveDown,
  output logic               OpenDoor,
  output logic               CloseDoor,
  output logic               stop,
  output logic [NFLOORS-1:0] pending,
  output logic               fault
);

  localparam int CNT_MAX = (HOLD_CYCLES > CLOSE_CYCLES) ? HOLD_CYCLES : CLOSE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]      HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]      CLOSE_LD  = CW'(CLOSE_CYCLES - 1);
  localparam logic [NFLOORS-1:0] FLOOR_ONE = NFLOORS'(1);

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN,
    DOOR_HOLD,
    DOOR_CLOSE
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DN
  } dir_t;

  state_t             state, state_next;
  dir_t               dir, dir_next;
  logic [CW-1:0]      hold_cnt, hold_cnt_next;
  logic [CW-1:0]      close_cnt, close_cnt_next;
  logic [NFLOORS-1:0] sensor_q;
  logic [NFLOORS-1:0] above_mask, below_mask;
  logic [NFLOORS-1:0] here, above, below, clr;
  logic               any_here, any_above, any_below;
  logic               moved, at_top, at_bottom;

  // A floor is "above" when some sensor bit sits strictly below it, and vice versa.
  genvar gi;
  generate
    for (gi = 0; gi < NFLOORS; gi++) begin : g_mask
      if (gi == 0) begin : g_bottom
        assign above_mask[gi] = 1'b0;
      end else begin : g_not_bottom
        assign above_mask[gi] = |Sensor[gi-1:0];
      end
      if (gi == NFLOORS - 1) begin : g_top
        assign below_mask[gi] = 1'b0;
      end else begin : g_not_top
        assign below_mask[gi] = |Sensor[NFLOORS-1:gi+1];
      end
    end
  endgenerate

  assign fault     = (Sensor == '0) || ((Sensor & (Sensor - FLOOR_ONE)) != '0);
  assign here      = pending & Sensor;
  assign above     = pending & above_mask;
  assign below     = pending & below_mask;
  assign any_here  = |here;
  assign any_above = |above;
  assign any_below = |below;
  assign moved     = (Sensor != sensor_q);
  assign at_top    = Sensor[NFLOORS-1];
  assign at_bottom = Sensor[0];

  // Calls at the current floor are absorbed from the passenger handshake until the door starts closing.
  assign clr = (((state == DOOR_OPEN) && Passenger_in) || (state == DOOR_HOLD)) ? Sensor : '0;

  always_comb begin
    state_next     = state;
    dir_next       = dir;
    hold_cnt_next  = hold_cnt;
    close_cnt_next = close_cnt;
    case (state)
      IDLE: begin
        if (!fault) begin
          if (any_here) begin
            state_next = DOOR_OPEN;
          end else if (dir == DIR_UP) begin
            if (any_above) begin
              state_next = MOVE_UP;
            end else if (any_below) begin
              state_next = MOVE_DOWN;
              dir_next   = DIR_DN;
            end
          end else begin
            if (any_below) begin
              state_next = MOVE_DOWN;
            end else if (any_above) begin
              state_next = MOVE_UP;
              dir_next   = DIR_UP;
            end
          end
        end
      end
      MOVE_UP: begin
        if (fault || at_top) begin
          state_next = IDLE;
        end else if (moved) begin
          if (any_here) begin
            state_next = DOOR_OPEN;
          end else if (!any_above) begin
            state_next = IDLE;
          end
        end
      end
      MOVE_DOWN: begin
        if (fault || at_bottom) begin
          state_next = IDLE;
        end else if (moved) begin
          if (any_here) begin
            state_next = DOOR_OPEN;
          end else if (!any_below) begin
            state_next = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        if (Passenger_in) begin
          state_next    = DOOR_HOLD;
          hold_cnt_next = HOLD_LD;
        end
      end
      DOOR_HOLD: begin
        if (hold_cnt == '0) begin
          state_next     = DOOR_CLOSE;
          close_cnt_next = CLOSE_LD;
        end else begin
          hold_cnt_next = hold_cnt - CNT_ONE;
        end
      end
      DOOR_CLOSE: begin
        if (close_cnt == '0) begin
          state_next = IDLE;
        end else begin
          close_cnt_next = close_cnt - CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Commands are decoded from the next state so they are valid in the first cycle of each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir       <= DIR_UP;
      hold_cnt  <= '0;
      close_cnt <= '0;
      sensor_q  <= '0;
      pending   <= '0;
      MoveUp    <= 1'b0;
      MoveDown  <= 1'b0;
      OpenDoor  <= 1'b0;
      CloseDoor <= 1'b0;
      stop      <= 1'b1;
    end else begin
      state     <= state_next;
      dir       <= dir_next;
      hold_cnt  <= hold_cnt_next;
      close_cnt <= close_cnt_next;
      sensor_q  <= Sensor;
      pending   <= (pending | req) & ~clr;
      MoveUp    <= (state_next == MOVE_UP);
      MoveDown  <= (state_next == MOVE_DOWN);
      OpenDoor  <= (state_next == DOOR_OPEN);
      CloseDoor <= (state_next == DOOR_CLOSE);
      stop      <= !((state_next == MOVE_UP) || (state_next == MOVE_DOWN));
    end
  end

endmodule
